// File: rtl/pwm_axi_lite_slave.sv
// pwm_axi_lite_slave
//   AXI4-Lite register slave with a PWM generator behind it.
//   Registers (addr[3:2] selects, addr[1:0] ignored), all 32-bit R/W:
//     0x0 CTRL (bit0 = enable), 0x4 PERIOD, 0x8 DUTY, 0xC PRESCALE.
//   PERIOD and DUTY are shadowed; the shadows reload only at a period wrap
//   or on the enable rising edge, so register writes never disturb a period
//   that is already running.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN   clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*             write address, write data, write response
//   S_AXI_AR*/R*                read address, read data
//   pwm_out                     registered PWM output
//
// Handshake rules: a transfer happens on a rising edge where VALID and READY
// are both high. A source holds VALID and its payload stable until that
// edge. BVALID/RVALID and their payloads stay put until BREADY/RREADY.
// AWREADY/WREADY drop while their holding register is full or a write
// response is pending; ARREADY drops while a read response is pending.
module pwm_axi_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_PWM_WIDTH        = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            pwm_out
);

    localparam int NB = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [C_PWM_WIDTH-1:0] PWM_ONE = {{(C_PWM_WIDTH-1){1'b0}}, 1'b1};

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [0:3];

    // Readies stay low in reset and come up on the first edge after release.
    logic                          out_of_reset;
    logic                          aw_held;
    logic [1:0]                    aw_addr_q;
    logic                          w_held;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
    logic [NB-1:0]                 w_strb_q;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;

    assign S_AXI_AWREADY = out_of_reset && !aw_held && !S_AXI_BVALID;
    assign S_AXI_WREADY  = out_of_reset && !w_held && !S_AXI_BVALID;
    assign S_AXI_ARREADY = out_of_reset && !S_AXI_RVALID;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Write path: AW and W land in separate holding registers in any order;
    // the register update happens on the edge after both are present.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            out_of_reset <= 1'b0;
            aw_held      <= 1'b0;
            aw_addr_q    <= '0;
            w_held       <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            S_AXI_BVALID <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                regs[r] <= '0;
            end
        end else begin
            out_of_reset <= 1'b1;
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (aw_held && w_held) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_strb_q[b]) begin
                        regs[aw_addr_q][8*b +: 8] <= w_data_q[8*b +: 8];
                    end
                end
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Read path: data is sampled from the register array as it stands before
    // the edge, so a read racing a commit to the same register sees old data.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_RDATA  <= '0;
            S_AXI_RVALID <= 1'b0;
        end else if (ar_hs) begin
            S_AXI_RDATA  <= regs[S_AXI_ARADDR[3:2]];
            S_AXI_RVALID <= 1'b1;
        end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

    // PWM engine
    logic                   enable;
    logic                   enable_d;
    logic [C_PWM_WIDTH-1:0] presc_cnt;
    logic [C_PWM_WIDTH-1:0] period_cnt;
    logic [C_PWM_WIDTH-1:0] period_sh;
    logic [C_PWM_WIDTH-1:0] duty_sh;
    logic                   tick;

    assign enable = regs[0][0];
    assign tick   = (presc_cnt >= regs[3][C_PWM_WIDTH-1:0]);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            enable_d   <= 1'b0;
            presc_cnt  <= '0;
            period_cnt <= '0;
            period_sh  <= '0;
            duty_sh    <= '0;
            pwm_out    <= 1'b0;
        end else if (!enable) begin
            enable_d   <= 1'b0;
            presc_cnt  <= '0;
            period_cnt <= '0;
            pwm_out    <= 1'b0;
        end else if (!enable_d) begin
            // Enable rising edge: take fresh shadows, start from count 0.
            enable_d   <= 1'b1;
            period_sh  <= regs[1][C_PWM_WIDTH-1:0];
            duty_sh    <= regs[2][C_PWM_WIDTH-1:0];
            presc_cnt  <= '0;
            period_cnt <= '0;
            pwm_out    <= 1'b0;
        end else begin
            pwm_out <= (period_sh != '0) && (period_cnt < duty_sh);
            if (tick) begin
                presc_cnt <= '0;
                // A zero period wraps every tick so that a later PERIOD write
                // still reaches the shadow while the output stays low.
                if ((period_sh == '0) || (period_cnt >= period_sh - PWM_ONE)) begin
                    period_cnt <= '0;
                    period_sh  <= regs[1][C_PWM_WIDTH-1:0];
                    duty_sh    <= regs[2][C_PWM_WIDTH-1:0];
                end else begin
                    period_cnt <= period_cnt + PWM_ONE;
                end
            end else begin
                presc_cnt <= presc_cnt + PWM_ONE;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           regs[0][C_S_AXI_DATA_WIDTH-1:1],
                           regs[1][C_S_AXI_DATA_WIDTH-1:C_PWM_WIDTH],
                           regs[2][C_S_AXI_DATA_WIDTH-1:C_PWM_WIDTH],
                           regs[3][C_S_AXI_DATA_WIDTH-1:C_PWM_WIDTH]};

endmodule

// File: tb/tb_pwm_axi_lite_slave.sv
// Self-checking bench for pwm_axi_lite_slave: table-driven register vectors,
// hand-written corner sequences, randomized register traffic against a
// reference register model, and PWM waveform checks against an arithmetic
// model of the expected output per clock.
module tb_pwm_axi_lite_slave;

    localparam int MAXC = 8192;
    localparam int NONE = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        pwm_out;

    pwm_axi_lite_slave dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .pwm_out      (pwm_out)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    // cyc = index of the most recent rising edge; pwm_hist[k] = pwm_out after edge k
    int   cyc = 0;
    logic pwm_hist [MAXC];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < MAXC) pwm_hist[cyc] <= pwm_out;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_regs [4];
    logic [31:0] exp_q [$];
    int          last_commit = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic void model_write(input logic [3:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        for (int i = 0; i < 4; i++)
            if (strb[i]) model_regs[addr[3:2]][8*i +: 8] = data[8*i +: 8];
    endfunction

    // Expected pwm_out after edge k, for enable committed at edge n.
    // Each count step lasts p+1 clocks; a period is t steps; the first
    // p+1-clock step starts at n+2; shadows load at n+1 and every period end.
    function automatic logic pwm_expect(input int k, input int n, input int p, input int t,
                                        input int d_old, input int d_new, input int chg);
        int len, j, pos, load_edge, duty, hi;
        if (k < n + 2 || t == 0) return 1'b0;
        len       = t * (p + 1);
        j         = (k - n - 2) / len;
        pos       = (k - n - 2) % len;
        load_edge = n + 1 + j * len;
        duty      = (chg < load_edge) ? d_new : d_old;
        hi        = ((duty < t) ? duty : t) * (p + 1);
        return (pos < hi) ? 1'b1 : 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w, seen = 0;
        int n = 0, hs_cyc = 0, hold_bad = 0;
        while (!(aw_done && w_done) && n < 40) begin
            if (!aw_done && n >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
            if (!w_done && n >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            if (hs_aw) begin aw_done = 1; awvalid = 1'b0; hs_cyc = cyc; end
            if (hs_w) begin w_done = 1; wvalid = 1'b0; hs_cyc = cyc; end
            n++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        for (int m = 0; m < 20 && !seen; m++) begin
            @(negedge clk);
            if (bvalid) seen = 1;
        end
        check("wr_bvalid_seen", 32'(seen), 32'd1);
        last_commit = cyc;
        check("wr_latency", 32'(last_commit - hs_cyc), 32'd1);
        check("wr_bresp", 32'(bresp), 32'd0);
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            if (!bvalid || bresp != 2'b00 || awready || wready) hold_bad++;
        end
        if (b_dly > 0) check("wr_b_hold", 32'(hold_bad), 32'd0);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("wr_b_single", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        model_write(addr, data, strb);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int r_dly, output logic [31:0] data);
        bit hs = 0;
        int n = 0, hold_bad = 0;
        arvalid = 1'b1;
        araddr  = addr;
        while (!hs && n < 40) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        data    = 'x;
        if (!hs) begin
            check("rd_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        @(negedge clk);
        check("rd_latency", 32'(rvalid), 32'd1);
        check("rd_rresp", 32'(rresp), 32'd0);
        data = rdata;
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            if (!rvalid || rdata !== data || arready) hold_bad++;
        end
        if (r_dly > 0) check("rd_r_hold", 32'(hold_bad), 32'd0);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        check("rd_r_single", 32'(rvalid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic pwm_start(input int p, input int t, input int d, output int n);
        axi_write(4'h0, 32'd0, 4'hF, 0, 0, 0);
        axi_write(4'hC, 32'(p), 4'hF, 0, 0, 0);
        axi_write(4'h4, 32'(t), 4'hF, 0, 0, 0);
        axi_write(4'h8, 32'(d), 4'hF, 0, 0, 0);
        axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
        n = last_commit;
    endtask

    task automatic check_pwm(input string name, input int n, input int win, input int p,
                             input int t, input int d_old, input int d_new, input int chg);
        int mism = 0, first = -1;
        while (cyc < n + win + 2) begin @(posedge clk); #1; end
        for (int k = n; k < n + win; k++) begin
            if (pwm_hist[k] !== pwm_expect(k, n, p, t, d_old, d_new, chg)) begin
                mism++;
                if (first < 0) first = k - n;
            end
        end
        check(name, 32'(mism), 32'd0);
        if (mism != 0) $display("  note: %s first wrong cycle offset %0d", name, first);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] final_exp [4];

    initial begin
        logic [31:0] rd, old, d;
        logic [3:0]  a, s;
        int          n, op, cnt;
        bit          hs, seen;

        vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 0, 0, 0, 32'h0000_0001};
        vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 0, 0, 0, 32'h0000_0002};
        vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 0, 0, 0, 32'h0000_0003};
        vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 0, 0, 5, 32'h0000_0004};
        vecs[4] = '{4'h8, 32'hDEAD_BEEF, 4'hF, 2, 0, 0, 32'hDEAD_BEEF};
        vecs[5] = '{4'h8, 32'h0000_5500, 4'h2, 0, 0, 0, 32'hDEAD_55EF};
        vecs[6] = '{4'h5, 32'hA5A5_0000, 4'hC, 0, 3, 0, 32'hA5A5_0002};
        final_exp[0] = 32'h0000_0001;
        final_exp[1] = 32'hA5A5_0002;
        final_exp[2] = 32'hDEAD_55EF;
        final_exp[3] = 32'h0000_0004;
        for (int i = 0; i < 4; i++) model_regs[i] = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_awready_before_edge", 32'(awready), 32'd0);
        @(posedge clk); #1;
        check("rel_awready", 32'(awready), 32'd1);
        check("rel_wready", 32'(wready), 32'd1);
        check("rel_arready", 32'(arready), 32'd1);
        for (int r = 0; r < 4; r++) begin
            axi_read(4'(r * 4), 0, rd);
            check("rst_reg_value", rd, 32'd0);
        end

        // ---- table-driven register vectors ----
        for (int i = 0; i < 7; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                      vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_dly);
            axi_read(vecs[i].addr, 0, rd);
            check("vec_readback", rd, vecs[i].exp_rd);
        end
        for (int r = 0; r < 4; r++) begin
            axi_read(4'(r * 4), (r == 2) ? 5 : 0, rd);
            check("vec_final_readback", rd, final_exp[r]);
        end

        // ---- read racing a commit to the same register returns old data ----
        old     = model_regs[2];
        awvalid = 1'b1; awaddr = 4'h8;
        wvalid  = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 4'h8;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("race_rvalid", 32'(rvalid), 32'd1);
        check("race_rdata_old", rdata, old);
        check("race_bvalid", 32'(bvalid), 32'd1);
        rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        @(posedge clk); #1;
        model_write(4'h8, 32'h1234_5678, 4'hF);
        axi_read(4'h8, 0, rd);
        check("race_rdata_new", rd, 32'h1234_5678);

        // ---- randomized traffic against the register model ----
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            a  = 4'($urandom_range(0, 15));
            if (op != 2) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                exp_q.push_back(model_regs[a[3:2]]);
                axi_read(a, $urandom_range(0, 2), rd);
                check("rand_readback", rd, exp_q.pop_front());
            end
        end

        // ---- PWM waveforms ----
        pwm_start(0, 10, 3, n);
        check_pwm("pwm_p10_d3", n, 45, 0, 10, 3, 3, NONE);

        pwm_start(0, 10, 3, n);
        while (cyc < n + 16) begin @(posedge clk); #1; end
        axi_write(4'h8, 32'd7, 4'hF, 0, 0, 0);
        check_pwm("pwm_duty_change_mid_period", n, 60, 0, 10, 3, 7, last_commit);

        pwm_start(0, 10, 12, n);
        check_pwm("pwm_duty_over_period_high", n, 35, 0, 10, 12, 12, NONE);

        pwm_start(0, 0, 3, n);
        check_pwm("pwm_period_zero_low", n, 30, 0, 0, 3, 3, NONE);

        pwm_start(0, 10, 0, n);
        check_pwm("pwm_duty_zero_low", n, 30, 0, 10, 0, 0, NONE);

        pwm_start(1, 4, 2, n);
        check_pwm("pwm_prescale1_p4_d2", n, 40, 1, 4, 2, 2, NONE);

        // ---- reset mid-transaction: AW held and a read response pending ----
        awvalid = 1'b1; awaddr = 4'h4;
        arvalid = 1'b1; araddr = 4'h0;
        @(posedge clk); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_rvalid", 32'(rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_awready", 32'(awready), 32'd0);
        check("mid_rst_wready", 32'(wready), 32'd0);
        check("mid_rst_arready", 32'(arready), 32'd0);
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        check("mid_rst_pwm", 32'(pwm_out), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) model_regs[i] = '0;

        // W alone must not pair with the address dropped by reset
        wvalid = 1'b1; wdata = 32'h0000_0077; wstrb = 4'hF;
        @(negedge clk);
        hs = wready;
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("post_rst_wready", 32'(hs), 32'd1);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bvalid || rvalid) cnt++;
        end
        check("post_rst_no_stale_resp", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = 4'h4;
        @(negedge clk);
        hs = awready;
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("post_rst_aw", 32'(hs), 32'd1);
        bready = 1'b1;
        seen   = 0;
        for (int m = 0; m < 10 && !seen; m++) begin
            @(negedge clk);
            if (bvalid) seen = 1;
        end
        @(posedge clk); #1;
        bready = 1'b0;
        check("post_rst_bvalid", 32'(seen), 32'd1);
        model_write(4'h4, 32'h0000_0077, 4'hF);
        @(posedge clk); #1;
        for (int r = 0; r < 4; r++) begin
            exp_q.push_back(model_regs[r]);
            axi_read(4'(r * 4), 0, rd);
            check("post_rst_readback", rd, exp_q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
